// File: rtl/hash_table_pkg.sv
// Shared types and helpers for the hash-table storage control blocks.
package hash_table_pkg;

  // Clear sequencer states, in the order the sequence walks them.
  typedef enum logic [2:0] {
    IDLE,
    FENCE,
    DRAIN,
    CLEAR,
    INIT,
    DONE
  } ht_clear_state_t;

  // Sweep counter width: widest target address plus one terminating MSB.
  function automatic int unsigned clear_cnt_width(input int unsigned data_a_w,
                                                  input int unsigned head_a_w);
    return ((data_a_w > head_a_w) ? data_a_w : head_a_w) + 1;
  endfunction

endpackage

// File: rtl/ht_clear_addr_gen.sv
// Address sweep for the clear: one address per step, with per-target range flags.
module ht_clear_addr_gen
  import hash_table_pkg::*;
#(
  parameter int unsigned DATA_A_WIDTH = 10,
  parameter int unsigned HEAD_A_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    start,
  input  logic                    step,
  output logic [DATA_A_WIDTH-1:0] data_addr,
  output logic [HEAD_A_WIDTH-1:0] head_addr,
  output logic                    data_in_range,
  output logic                    head_in_range,
  output logic                    last
);

  localparam int unsigned CNT_W = clear_cnt_width(DATA_A_WIDTH, HEAD_A_WIDTH);

  logic [CNT_W-1:0] cnt_q;

  // Sweep counter: held at zero by start, advanced by step; the extra MSB stops wrap-around.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
    end else if (step) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign data_addr     = cnt_q[DATA_A_WIDTH-1:0];
  assign head_addr     = cnt_q[HEAD_A_WIDTH-1:0];
  assign data_in_range = (cnt_q >> DATA_A_WIDTH) == '0;
  assign head_in_range = (cnt_q >> HEAD_A_WIDTH) == '0;
  assign last          = (cnt_q == {1'b0, {(CNT_W-1){1'b1}}});

endmodule

// File: rtl/ht_clear_ctrl.sv
// Full hash-table clear sequencer: fence ingress, drain engines, sweep data RAM and
// head table, reload empty pointers, then pulse done.
module ht_clear_ctrl
  import hash_table_pkg::*;
#(
  parameter int unsigned D_WIDTH      = 64,
  parameter int unsigned DATA_A_WIDTH = 10,
  parameter int unsigned HEAD_A_WIDTH = 8,
  parameter int unsigned RAM_LATENCY  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    clear_run_i,
  output logic                    clear_busy_o,
  output logic                    clear_done_o,
  output logic                    collision_err_o,
  input  logic                    task_valid_i,
  output logic                    task_ready_o,
  output logic                    task_valid_o,
  input  logic                    task_ready_i,
  input  logic                    eng_busy_i,
  input  logic [DATA_A_WIDTH-1:0] eng_wr_addr_i,
  input  logic [D_WIDTH-1:0]      eng_wr_data_i,
  input  logic                    eng_wr_en_i,
  output logic [DATA_A_WIDTH-1:0] ram_wr_addr_o,
  output logic [D_WIDTH-1:0]      ram_wr_data_o,
  output logic                    ram_wr_en_o,
  output logic [HEAD_A_WIDTH-1:0] ht_clr_addr_o,
  output logic                    ht_clr_en_o,
  output logic                    eptr_init_o
);

  localparam int unsigned QUIET_W = $clog2(RAM_LATENCY + 2);

  ht_clear_state_t         state_q;
  logic [QUIET_W-1:0]      quiet_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    eptr_init_q;
  logic                    err_q;

  logic                    in_clear;
  logic                    sweep_data_ok;
  logic                    sweep_head_ok;
  logic                    sweep_last;
  logic [DATA_A_WIDTH-1:0] sweep_data_addr;
  logic [HEAD_A_WIDTH-1:0] sweep_head_addr;

  assign in_clear = (state_q == CLEAR);

  ht_clear_addr_gen #(
    .DATA_A_WIDTH (DATA_A_WIDTH),
    .HEAD_A_WIDTH (HEAD_A_WIDTH)
  ) u_addr_gen (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .start         (!in_clear),
    .step          (in_clear),
    .data_addr     (sweep_data_addr),
    .head_addr     (sweep_head_addr),
    .data_in_range (sweep_data_ok),
    .head_in_range (sweep_head_ok),
    .last          (sweep_last)
  );

  // Sequencer FSM with registered busy/done/eptr_init flags.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      quiet_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      eptr_init_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      eptr_init_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clear_run_i) begin
            state_q <= FENCE;
            busy_q  <= 1'b1;
          end
        end
        FENCE: begin
          if (!eng_busy_i) begin
            state_q <= DRAIN;
            quiet_q <= '0;
          end
        end
        DRAIN: begin
          if (eng_busy_i) begin
            state_q <= FENCE;
            quiet_q <= '0;
          end else if (quiet_q == QUIET_W'(RAM_LATENCY)) begin
            state_q <= CLEAR;
            quiet_q <= '0;
          end else begin
            quiet_q <= quiet_q + QUIET_W'(1);
          end
        end
        CLEAR: begin
          if (sweep_last) begin
            state_q     <= INIT;
            eptr_init_q <= 1'b1;
          end
        end
        INIT: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flag: an engine tried to write while the sweep owned the RAM port.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_q <= 1'b0;
    end else if (in_clear && eng_wr_en_i) begin
      err_q <= 1'b1;
    end
  end

  assign clear_busy_o    = busy_q;
  assign clear_done_o    = done_q;
  assign eptr_init_o     = eptr_init_q;
  assign collision_err_o = err_q;

  // Ingress gating follows the registered busy flag, so a task offered in the run cycle still passes.
  assign task_ready_o = task_ready_i && !busy_q;
  assign task_valid_o = task_valid_i && !busy_q;

  // RAM port: sweep owns it during CLEAR, engines everywhere else.
  assign ram_wr_en_o   = in_clear ? sweep_data_ok : eng_wr_en_i;
  assign ram_wr_addr_o = in_clear ? sweep_data_addr : eng_wr_addr_i;
  assign ram_wr_data_o = in_clear ? {D_WIDTH{1'b0}} : eng_wr_data_i;

  assign ht_clr_en_o   = in_clear && sweep_head_ok;
  assign ht_clr_addr_o = in_clear ? sweep_head_addr : {HEAD_A_WIDTH{1'b0}};

endmodule

// File: tb/tb_ht_clear_ctrl.sv
// Scoreboard bench for ht_clear_ctrl: schedule-level model feeds an expected-event queue,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_ht_clear_ctrl;

  localparam int unsigned D_WIDTH      = 16;
  localparam int unsigned DATA_A_WIDTH = 4;
  localparam int unsigned HEAD_A_WIDTH = 3;
  localparam int unsigned RAM_LATENCY  = 2;

  localparam int RL         = 2;
  localparam int DATA_DEPTH = 16;
  localparam int HEAD_DEPTH = 8;
  localparam int SWEEP      = 16;
  localparam int MAXC       = 64;

  localparam logic [1:0] EV_RAM  = 2'd0;
  localparam logic [1:0] EV_HT   = 2'd1;
  localparam logic [1:0] EV_EPTR = 2'd2;
  localparam logic [1:0] EV_DONE = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] cyc;
    logic [3:0]  addr;
    logic [15:0] data;
  } ev_t;

  logic                    clk_i = 1'b0;
  logic                    rst_n_i = 1'b1;
  logic                    clear_run_i;
  logic                    clear_busy_o;
  logic                    clear_done_o;
  logic                    collision_err_o;
  logic                    task_valid_i;
  logic                    task_ready_o;
  logic                    task_valid_o;
  logic                    task_ready_i;
  logic                    eng_busy_i;
  logic [DATA_A_WIDTH-1:0] eng_wr_addr_i;
  logic [D_WIDTH-1:0]      eng_wr_data_i;
  logic                    eng_wr_en_i;
  logic [DATA_A_WIDTH-1:0] ram_wr_addr_o;
  logic [D_WIDTH-1:0]      ram_wr_data_o;
  logic                    ram_wr_en_o;
  logic [HEAD_A_WIDTH-1:0] ht_clr_addr_o;
  logic                    ht_clr_en_o;
  logic                    eptr_init_o;

  always #5 clk_i = ~clk_i;

  ht_clear_ctrl #(
    .D_WIDTH      (D_WIDTH),
    .DATA_A_WIDTH (DATA_A_WIDTH),
    .HEAD_A_WIDTH (HEAD_A_WIDTH),
    .RAM_LATENCY  (RAM_LATENCY)
  ) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .clear_run_i     (clear_run_i),
    .clear_busy_o    (clear_busy_o),
    .clear_done_o    (clear_done_o),
    .collision_err_o (collision_err_o),
    .task_valid_i    (task_valid_i),
    .task_ready_o    (task_ready_o),
    .task_valid_o    (task_valid_o),
    .task_ready_i    (task_ready_i),
    .eng_busy_i      (eng_busy_i),
    .eng_wr_addr_i   (eng_wr_addr_i),
    .eng_wr_data_i   (eng_wr_data_i),
    .eng_wr_en_i     (eng_wr_en_i),
    .ram_wr_addr_o   (ram_wr_addr_o),
    .ram_wr_data_o   (ram_wr_data_o),
    .ram_wr_en_o     (ram_wr_en_o),
    .ht_clr_addr_o   (ht_clr_addr_o),
    .ht_clr_en_o     (ht_clr_en_o),
    .eptr_init_o     (eptr_init_o)
  );

  // Per-cycle stimulus of the current scenario.
  bit          run_a  [MAXC];
  bit          busy_a [MAXC];
  bit          wen_a  [MAXC];
  bit          tv_a   [MAXC];
  bit          tr_a   [MAXC];
  logic [3:0]  waddr_a[MAXC];
  logic [15:0] wdata_a[MAXC];

  // Model expectations.
  bit   exp_busy[MAXC];
  bit   exp_err [MAXC];
  ev_t  exp_q[$];
  bit   err_sticky;

  int   scn_cyc;
  bit   scn_active;
  bit   end_chk;
  int   n_checks;
  int   n_fails;

  task automatic check_bit(input string nm, input logic got, input logic expv);
    n_checks++;
    if (got !== expv) begin
      n_fails++;
      $display("FAIL %s cycle %0d: got %b expected %b", nm, scn_cyc, got, expv);
    end
  endtask

  task automatic check_ev(input ev_t got);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fails++;
      $display("FAIL unexpected_event: got kind %0d cyc %0d addr %0d data %h, expected none",
               got.kind, got.cyc, got.addr, got.data);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_fails++;
        $display("FAIL event: got kind %0d cyc %0d addr %0d data %h, expected kind %0d cyc %0d addr %0d data %h",
                 got.kind, got.cyc, got.addr, got.data, e.kind, e.cyc, e.addr, e.data);
      end
    end
  endtask

  // Monitor: reset-value checks while reset is low, per-cycle checks while a scenario runs.
  always @(negedge clk_i or negedge rst_n_i) begin : mon
    int  n;
    ev_t got;
    if (!rst_n_i) begin
      #1;
      check_bit("rst_busy", clear_busy_o, 1'b0);
      check_bit("rst_done", clear_done_o, 1'b0);
      check_bit("rst_err", collision_err_o, 1'b0);
      check_bit("rst_eptr_init", eptr_init_o, 1'b0);
      check_bit("rst_ht_clr_en", ht_clr_en_o, 1'b0);
      check_bit("rst_ram_wr_en", ram_wr_en_o, 1'b0);
      check_bit("rst_ram_addr_nonzero", ram_wr_addr_o != '0, 1'b0);
      check_bit("rst_ram_data_nonzero", ram_wr_data_o != '0, 1'b0);
    end else if (scn_active) begin
      n = scn_cyc;
      check_bit("busy", clear_busy_o, exp_busy[n]);
      check_bit("task_valid_o", task_valid_o, tv_a[n] && !exp_busy[n]);
      check_bit("task_ready_o", task_ready_o, tr_a[n] && !exp_busy[n]);
      check_bit("collision_err", collision_err_o, exp_err[n]);
      if (ram_wr_en_o) begin
        got = {EV_RAM, 16'(n), ram_wr_addr_o, ram_wr_data_o};
        check_ev(got);
      end
      if (ht_clr_en_o) begin
        got = {EV_HT, 16'(n), {1'b0, ht_clr_addr_o}, 16'h0000};
        check_ev(got);
      end
      if (eptr_init_o) begin
        got = {EV_EPTR, 16'(n), 4'h0, 16'h0000};
        check_ev(got);
      end
      if (clear_done_o) begin
        got = {EV_DONE, 16'(n), 4'h0, 16'h0000};
        check_ev(got);
      end
    end else if (end_chk) begin
      n_checks++;
      if (exp_q.size() != 0) begin
        n_fails++;
        $display("FAIL missing_events: got %0d outstanding, expected 0 (next kind %0d cyc %0d)",
                 exp_q.size(), exp_q[0].kind, exp_q[0].cyc);
      end
    end
  end

  function automatic bit quiet_from(input int k);
    for (int j = k; j < k + RL + 2; j++) begin
      if (j < MAXC && busy_a[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Schedule model: after a run, the fence opens the next cycle; the sweep begins once
  // RL+2 consecutive quiet engine cycles have elapsed, lasts SWEEP cycles, then eptr_init, then done.
  task automatic build_model(input int len);
    int  b0;
    int  b1;
    int  cs;
    int  k;
    bit  in_seq;
    bit  in_clr;
    ev_t e;
    b0 = 1;
    b1 = 0;
    cs = -100;
    for (int n = 0; n < len; n++) begin
      in_seq = (n >= b0) && (n <= b1);
      if (!in_seq && run_a[n]) begin
        k = n + 1;
        while (k < MAXC && !quiet_from(k)) k++;
        cs = k + RL + 2;
        b0 = n + 1;
        b1 = cs + SWEEP + 1;
      end
      exp_busy[n] = in_seq;
      exp_err[n]  = err_sticky;
      in_clr = in_seq && (n >= cs) && (n < cs + SWEEP);
      if (in_clr) begin
        if (n - cs < DATA_DEPTH) begin
          e = {EV_RAM, 16'(n), 4'(n - cs), 16'h0000};
          exp_q.push_back(e);
        end
        if (n - cs < HEAD_DEPTH) begin
          e = {EV_HT, 16'(n), 4'(n - cs), 16'h0000};
          exp_q.push_back(e);
        end
        if (wen_a[n]) err_sticky = 1'b1;
      end else if (wen_a[n]) begin
        e = {EV_RAM, 16'(n), waddr_a[n], wdata_a[n]};
        exp_q.push_back(e);
      end
      if (in_seq && n == cs + SWEEP) begin
        e = {EV_EPTR, 16'(n), 4'h0, 16'h0000};
        exp_q.push_back(e);
      end
      if (in_seq && n == cs + SWEEP + 1) begin
        e = {EV_DONE, 16'(n), 4'h0, 16'h0000};
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic zero_inputs();
    clear_run_i   = 1'b0;
    eng_busy_i    = 1'b0;
    eng_wr_en_i   = 1'b0;
    eng_wr_addr_i = '0;
    eng_wr_data_i = '0;
    task_valid_i  = 1'b0;
    task_ready_i  = 1'b0;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      run_a[i]   = 1'b0;
      busy_a[i]  = 1'b0;
      wen_a[i]   = 1'b0;
      tv_a[i]    = 1'b0;
      tr_a[i]    = 1'b0;
      waddr_a[i] = '0;
      wdata_a[i] = '0;
    end
  endtask

  // Drive cycles 0..cut-1 of a scenario modelled over len cycles.
  task automatic drive(input int len, input int cut);
    build_model(len);
    for (int n = 0; n < cut; n++) begin
      @(posedge clk_i);
      #1;
      scn_cyc       = n;
      scn_active    = 1'b1;
      clear_run_i   = run_a[n];
      eng_busy_i    = busy_a[n];
      eng_wr_en_i   = wen_a[n];
      eng_wr_addr_i = waddr_a[n];
      eng_wr_data_i = wdata_a[n];
      task_valid_i  = tv_a[n];
      task_ready_i  = tr_a[n];
    end
    @(posedge clk_i);
    #1;
    scn_active = 1'b0;
    zero_inputs();
  endtask

  task automatic end_check();
    repeat (2) @(posedge clk_i);
    end_chk = 1'b1;
    @(negedge clk_i);
    #1;
    end_chk = 1'b0;
  endtask

  initial begin
    int t0;
    n_checks   = 0;
    n_fails    = 0;
    scn_active = 1'b0;
    end_chk    = 1'b0;
    scn_cyc    = 0;
    err_sticky = 1'b0;
    zero_inputs();
    clear_stim();
    #1 rst_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #2 rst_n_i = 1'b1;

    // Idle engines: full sweep timing.
    clear_stim();
    run_a[0] = 1'b1;
    drive(30, 30);
    end_check();

    // Engines busy after run, then a busy glitch inside the drain window.
    clear_stim();
    run_a[0] = 1'b1;
    for (int i = 1; i <= 5; i++) busy_a[i] = 1'b1;
    busy_a[8] = 1'b1;
    drive(40, 40);
    end_check();

    // Ingress held valid across the clear, including the run cycle.
    clear_stim();
    run_a[2] = 1'b1;
    for (int i = 0; i < MAXC; i++) begin
      tv_a[i] = 1'b1;
      tr_a[i] = 1'b1;
    end
    drive(32, 32);
    end_check();

    // Idle passthrough write, then an engine write colliding at sweep address 5.
    clear_stim();
    run_a[0]    = 1'b1;
    wen_a[0]    = 1'b1;
    waddr_a[0]  = 4'hA;
    wdata_a[0]  = 16'hBEEF;
    wen_a[10]   = 1'b1;
    waddr_a[10] = 4'h3;
    wdata_a[10] = 16'h1234;
    drive(30, 30);
    end_check();

    // Extra run requests during CLEAR and in the DONE cycle are ignored.
    clear_stim();
    run_a[0]  = 1'b1;
    run_a[12] = 1'b1;
    run_a[22] = 1'b1;
    drive(40, 40);
    end_check();

    // Reset at sweep address 9, then a complete re-run.
    clear_stim();
    run_a[0] = 1'b1;
    drive(30, 14);
    #1 rst_n_i = 1'b0;
    while (exp_q.size() != 0 && exp_q[exp_q.size()-1].cyc >= 16'd14) void'(exp_q.pop_back());
    err_sticky = 1'b0;
    repeat (3) @(posedge clk_i);
    #2 rst_n_i = 1'b1;
    end_check();

    clear_stim();
    run_a[0] = 1'b1;
    drive(30, 30);
    end_check();

    // Randomized engine activity, ingress traffic and spurious run requests.
    for (int r = 0; r < 6; r++) begin
      clear_stim();
      t0 = int'($urandom_range(0, 3));
      run_a[t0] = 1'b1;
      for (int n = 0; n < MAXC; n++) begin
        if (n > t0 && n <= t0 + 12) busy_a[n] = ($urandom_range(0, 2) == 0);
        if (n > t0 && n <= t0 + 20 && $urandom_range(0, 9) == 0) run_a[n] = 1'b1;
        wen_a[n]   = ($urandom_range(0, 3) == 0);
        waddr_a[n] = 4'($urandom);
        wdata_a[n] = 16'($urandom);
        tv_a[n]    = 1'($urandom_range(0, 1));
        tr_a[n]    = 1'($urandom_range(0, 1));
      end
      drive(t0 + 40, t0 + 40);
      end_check();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
